// File: rtl/uncached_resp_buf_pkg.sv
// Shared types and constants for the uncached response buffer.
// Optional same-cycle bypass is selected with the UC_RESP_BYPASS_EN macro.
package uncached_resp_buf_pkg;

  localparam int UC_DEPTH      = 8;
  localparam int DATA_WIDTH    = 32;
  localparam int LSU_IDX_W     = 4;

  localparam logic [1:0] UC_SZ_B = 2'd0;
  localparam logic [1:0] UC_SZ_H = 2'd1;
  localparam logic [1:0] UC_SZ_W = 2'd2;

  typedef logic [LSU_IDX_W-1:0] lsu_idx_t;

  typedef struct packed {
    logic       is_load;
    lsu_idx_t   lsu_idx;
    logic [1:0] addr_lo;
    logic [1:0] size;
    logic       sign_ext;
  } uc_meta_t;

  typedef struct packed {
    lsu_idx_t              lsu_idx;
    logic [DATA_WIDTH-1:0] rddata;
    logic                  rddata_vld;
  } lsu_resp_t;

endpackage

// File: rtl/uncached_resp_buf_load_align.sv
// Combinational load-data alignment and sign/zero extension; stores return zero.
// Shared by the registered writeback path and the same-cycle bypass path.
module uc_load_align
  import uncached_resp_buf_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rddata_i,
  input  uc_meta_t              meta_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rddata_i[{meta_i.addr_lo, 3'b000} +: 8];
    half_sel = rddata_i[{meta_i.addr_lo[1], 4'b0000} +: 16];
  end

  always_comb begin
    data_o = '0;
    if (meta_i.is_load) begin
      case (meta_i.size)
        UC_SZ_B: data_o = {{(DATA_WIDTH-8){meta_i.sign_ext & byte_sel[7]}}, byte_sel};
        UC_SZ_H: data_o = {{(DATA_WIDTH-16){meta_i.sign_ext & half_sel[15]}}, half_sel};
        default: data_o = rddata_i;
      endcase
    end
  end

endmodule

// File: rtl/uncached_resp_buf.sv
// In-order completion buffer for uncached pass-queue responses with credit-based admission.
// Define UC_RESP_BYPASS_EN to let a response filling the head entry retire in the same cycle.
module uncached_resp_buf
  import uncached_resp_buf_pkg::*;
#(
  parameter int DEPTH = UC_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_push_i,
  input  uc_meta_t              req_meta_i,
  output logic                  credit_ok_o,
  input  lsu_resp_t             pass_resp_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output lsu_idx_t              wb_lsu_idx_o,
  output logic                  wb_is_load_o,
  output logic [DATA_WIDTH-1:0] wb_rddata_o,
  output logic                  err_order_o,
  output logic                  err_ovf_o
);

  localparam int SLOT_W = $clog2(DEPTH);
  localparam int PTR_W  = SLOT_W + 1;

  // Pointers carry one extra wrap bit so occ can distinguish full from empty.
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [PTR_W-1:0]      fill_q, fill_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic                  err_order_q, err_order_d;
  logic                  err_ovf_q, err_ovf_d;
  uc_meta_t              meta_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [SLOT_W-1:0]     tail_s, fill_s, head_s;
  logic [PTR_W-1:0]      occ;
  logic                  alloc, fill_pend, do_fill, byp_hit, retire;
  uc_meta_t              head_meta;
  logic [DATA_WIDTH-1:0] head_data;

  assign tail_s = tail_q[SLOT_W-1:0];
  assign fill_s = fill_q[SLOT_W-1:0];
  assign head_s = head_q[SLOT_W-1:0];
  assign occ    = tail_q - head_q;

  assign credit_ok_o = ~rst & (occ < PTR_W'(DEPTH));
  assign alloc       = req_push_i & credit_ok_o;
  assign fill_pend   = (fill_q != tail_q);
  assign do_fill     = pass_resp_i.rddata_vld & fill_pend;

`ifdef UC_RESP_BYPASS_EN
  assign byp_hit = do_fill & (fill_q == head_q);
`else
  assign byp_hit = 1'b0;
`endif

  assign head_meta  = meta_q[head_s];
  assign head_data  = byp_hit ? pass_resp_i.rddata : data_q[head_s];
  assign wb_valid_o = filled_q[head_s] | byp_hit;
  assign retire     = wb_valid_o & wb_ready_i;

  uc_load_align u_align (
    .rddata_i (head_data),
    .meta_i   (head_meta),
    .data_o   (wb_rddata_o)
  );

  assign wb_lsu_idx_o = head_meta.lsu_idx;
  assign wb_is_load_o = head_meta.is_load;
  assign err_order_o  = err_order_q;
  assign err_ovf_o    = err_ovf_q;

  always_comb begin
    tail_d      = tail_q;
    fill_d      = fill_q;
    head_d      = head_q;
    filled_d    = filled_q;
    err_order_d = err_order_q;
    err_ovf_d   = err_ovf_q;

    if (alloc) begin
      filled_d[tail_s] = 1'b0;
      tail_d           = tail_q + 1'b1;
    end
    if (req_push_i & ~credit_ok_o) begin
      err_ovf_d = 1'b1;
    end

    if (do_fill) begin
      filled_d[fill_s] = 1'b1;
      fill_d           = fill_q + 1'b1;
      if (pass_resp_i.lsu_idx != meta_q[fill_s].lsu_idx) begin
        err_order_d = 1'b1;
      end
    end
    if (pass_resp_i.rddata_vld & ~fill_pend) begin
      err_order_d = 1'b1;
    end

    // A bypassed fill is set and cleared here in the same cycle, leaving the slot free.
    if (retire) begin
      filled_d[head_s] = 1'b0;
      head_d           = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail_q      <= '0;
      fill_q      <= '0;
      head_q      <= '0;
      filled_q    <= '0;
      err_order_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      head_q      <= head_d;
      filled_q    <= filled_d;
      err_order_q <= err_order_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        meta_q[tail_s] <= req_meta_i;
      end
      if (do_fill) begin
        data_q[fill_s] <= pass_resp_i.rddata;
      end
    end
  end

endmodule

// File: tb/tb_uncached_resp_buf.sv
// Self-checking bench for uncached_resp_buf: alignment table, directed corner cases, random model run.
module tb_uncached_resp_buf;
  import uncached_resp_buf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_push;
  uc_meta_t    req_meta;
  logic        credit_ok;
  lsu_resp_t   pass_resp;
  logic        wb_valid;
  logic        wb_ready;
  lsu_idx_t    wb_lsu_idx;
  logic        wb_is_load;
  logic [31:0] wb_rddata;
  logic        err_order;
  logic        err_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uncached_resp_buf dut (
    .clk          (clk),
    .rst          (rst),
    .req_push_i   (req_push),
    .req_meta_i   (req_meta),
    .credit_ok_o  (credit_ok),
    .pass_resp_i  (pass_resp),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_lsu_idx_o (wb_lsu_idx),
    .wb_is_load_o (wb_is_load),
    .wb_rddata_o  (wb_rddata),
    .err_order_o  (err_order),
    .err_ovf_o    (err_ovf)
  );

  typedef struct {
    logic        is_load;
    logic [3:0]  idx;
    logic [1:0]  addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    uc_meta_t    m;
    logic [31:0] d;
    bit          f;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    req_push  = 1'b0;
    req_meta  = '0;
    pass_resp = '0;
    wb_ready  = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr_inputs();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic drive_push(input logic [3:0] idx, input logic ld, input logic [1:0] addr,
                            input logic [1:0] size, input logic sgn);
    req_push          = 1'b1;
    req_meta.is_load  = ld;
    req_meta.lsu_idx  = idx;
    req_meta.addr_lo  = addr;
    req_meta.size     = size;
    req_meta.sign_ext = sgn;
  endtask

  task automatic drive_resp(input logic [3:0] idx, input logic [31:0] rd);
    pass_resp.rddata_vld = 1'b1;
    pass_resp.lsu_idx    = idx;
    pass_resp.rddata     = rd;
  endtask

  // Reference alignment computed from shift-and-mask arithmetic.
  function automatic logic [31:0] ref_align(input uc_meta_t m, input logic [31:0] rd);
    logic [31:0] v;
    if (!m.is_load) return 32'h0;
    if (m.size == 2'd0) begin
      v = (rd >> (32'(m.addr_lo) * 8)) & 32'hFF;
      if (m.sign_ext && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (m.size == 2'd1) begin
      v = (rd >> (32'(m.addr_lo[1]) * 16)) & 32'hFFFF;
      if (m.sign_ext && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  vec_t vecs [8];
  ent_t q [$];

  initial begin
    clr_inputs();

    vecs[0] = '{1'b1, 4'd3, 2'd2, 2'd0, 1'b1, 32'h1280_FF00, 32'hFFFF_FF80};
    vecs[1] = '{1'b1, 4'd3, 2'd2, 2'd0, 1'b0, 32'h1280_FF00, 32'h0000_0080};
    vecs[2] = '{1'b0, 4'd5, 2'd0, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[3] = '{1'b1, 4'd1, 2'd2, 2'd1, 1'b1, 32'h8001_1234, 32'hFFFF_8001};
    vecs[4] = '{1'b1, 4'd2, 2'd0, 2'd1, 1'b0, 32'h0000_F00D, 32'h0000_F00D};
    vecs[5] = '{1'b1, 4'd4, 2'd0, 2'd2, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 4'd6, 2'd0, 2'd0, 1'b1, 32'h0000_007F, 32'h0000_007F};
    vecs[7] = '{1'b1, 4'd9, 2'd3, 2'd0, 1'b0, 32'h8100_0000, 32'h0000_0081};

    do_reset();
    chk("reset_wb_valid", 32'(wb_valid), 32'h0);
    chk("reset_credit", 32'(credit_ok), 32'h1);
    chk("reset_err_order", 32'(err_order), 32'h0);
    chk("reset_err_ovf", 32'(err_ovf), 32'h0);
    chk("reset_wb_rddata", wb_rddata, 32'h0);
    chk("reset_wb_idx", 32'(wb_lsu_idx), 32'h0);

    for (int i = 0; i < 8; i++) begin
      drive_push(vecs[i].idx, vecs[i].is_load, vecs[i].addr, vecs[i].size, vecs[i].sgn);
      cyc();
      chk("vec_no_early_valid", 32'(wb_valid), 32'h0);
      drive_resp(vecs[i].idx, vecs[i].rd);
      cyc();
      chk("vec_wb_valid", 32'(wb_valid), 32'h1);
      chk("vec_wb_idx", 32'(wb_lsu_idx), 32'(vecs[i].idx));
      chk("vec_wb_is_load", 32'(wb_is_load), 32'(vecs[i].is_load));
      chk("vec_wb_rddata", wb_rddata, vecs[i].exp);
      wb_ready = 1'b1;
      cyc();
      chk("vec_retired", 32'(wb_valid), 32'h0);
    end
    chk("vec_err_order", 32'(err_order), 32'h0);

    // Fill all eight slots, then overflow.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("full_credit_before", 32'(credit_ok), 32'h1);
      drive_push(4'(i), 1'b1, 2'd0, 2'd2, 1'b0);
      cyc();
    end
    chk("full_credit_zero", 32'(credit_ok), 32'h0);
    drive_push(4'd8, 1'b1, 2'd0, 2'd2, 1'b0);
    cyc();
    chk("full_err_ovf", 32'(err_ovf), 32'h1);
    chk("full_still_full", 32'(credit_ok), 32'h0);
    drive_resp(4'd0, 32'h1111_2222);
    cyc();
    chk("full_head_valid", 32'(wb_valid), 32'h1);
    chk("full_credit_held", 32'(credit_ok), 32'h0);
    wb_ready = 1'b1;
    cyc();
    chk("full_credit_back", 32'(credit_ok), 32'h1);
    chk("full_err_order", 32'(err_order), 32'h0);

    // Back-pressure: three completions while writeback stalls.
    do_reset();
    drive_push(4'd1, 1'b1, 2'd0, 2'd2, 1'b0); cyc();
    drive_push(4'd2, 1'b1, 2'd0, 2'd2, 1'b0); cyc();
    drive_push(4'd4, 1'b1, 2'd0, 2'd2, 1'b0); cyc();
    drive_resp(4'd1, 32'hAAAA_0001); cyc();
    chk("hold_valid", 32'(wb_valid), 32'h1);
    drive_resp(4'd2, 32'hBBBB_0002); cyc();
    chk("hold_idx_a", 32'(wb_lsu_idx), 32'd1);
    chk("hold_data_a", wb_rddata, 32'hAAAA_0001);
    drive_resp(4'd4, 32'hCCCC_0004); cyc();
    chk("hold_idx_b", 32'(wb_lsu_idx), 32'd1);
    chk("hold_data_b", wb_rddata, 32'hAAAA_0001);
    chk("hold_valid_b", 32'(wb_valid), 32'h1);
    wb_ready = 1'b1; #1;
    chk("rel_idx1", 32'(wb_lsu_idx), 32'd1);
    cyc();
    wb_ready = 1'b1; #1;
    chk("rel_valid2", 32'(wb_valid), 32'h1);
    chk("rel_idx2", 32'(wb_lsu_idx), 32'd2);
    chk("rel_data2", wb_rddata, 32'hBBBB_0002);
    cyc();
    wb_ready = 1'b1; #1;
    chk("rel_valid4", 32'(wb_valid), 32'h1);
    chk("rel_idx4", 32'(wb_lsu_idx), 32'd4);
    chk("rel_data4", wb_rddata, 32'hCCCC_0004);
    cyc();
    chk("rel_empty", 32'(wb_valid), 32'h0);

    // Ordering errors.
    do_reset();
    drive_push(4'd6, 1'b1, 2'd0, 2'd2, 1'b0); cyc();
    drive_resp(4'd7, 32'h0000_0055); cyc();
    chk("order_err_mismatch", 32'(err_order), 32'h1);
    chk("order_still_valid", 32'(wb_valid), 32'h1);
    chk("order_head_idx", 32'(wb_lsu_idx), 32'd6);
    wb_ready = 1'b1; cyc();
    chk("order_retired", 32'(wb_valid), 32'h0);
    chk("order_sticky", 32'(err_order), 32'h1);
    do_reset();
    chk("order_cleared", 32'(err_order), 32'h0);
    drive_resp(4'd3, 32'h0); cyc();
    chk("order_err_empty", 32'(err_order), 32'h1);
    chk("order_empty_novalid", 32'(wb_valid), 32'h0);

    // Alloc + fill + retire together at occ = DEPTH-1.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_push(4'(i), 1'b1, 2'd0, 2'd2, 1'b0);
      cyc();
    end
    drive_resp(4'd0, 32'h0000_1000); cyc();
    drive_push(4'd7, 1'b1, 2'd0, 2'd2, 1'b0);
    drive_resp(4'd1, 32'h0000_1001);
    wb_ready = 1'b1;
    cyc();
    chk("simul_credit", 32'(credit_ok), 32'h1);
    chk("simul_err_order", 32'(err_order), 32'h0);
    chk("simul_err_ovf", 32'(err_ovf), 32'h0);
    chk("simul_head_idx", 32'(wb_lsu_idx), 32'd1);
    chk("simul_head_valid", 32'(wb_valid), 32'h1);
    drive_push(4'd8, 1'b1, 2'd0, 2'd2, 1'b0); cyc();
    chk("simul_now_full", 32'(credit_ok), 32'h0);

    // Reset mid-stream.
    rst = 1'b1; cyc(); rst = 1'b0; #1;
    chk("midrst_valid", 32'(wb_valid), 32'h0);
    chk("midrst_credit", 32'(credit_ok), 32'h1);

`ifdef UC_RESP_BYPASS_EN
    do_reset();
    drive_push(4'd9, 1'b1, 2'd1, 2'd0, 1'b0); cyc();
    drive_resp(4'd9, 32'h0000_AB00);
    wb_ready = 1'b1;
    #1;
    chk("byp_same_cycle_valid", 32'(wb_valid), 32'h1);
    chk("byp_same_cycle_data", wb_rddata, 32'h0000_00AB);
    cyc();
    chk("byp_retired", 32'(wb_valid), 32'h0);
`endif

    // Random traffic against a queue-based model.
    do_reset();
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      int          nfill;
      bit          do_push, do_resp, rdy, exp_v, byp;
      logic [31:0] rd, exp_d;
      uc_meta_t    m;
      nfill = -1;
      for (int k = 0; k < q.size(); k++) begin
        if (!q[k].f) begin
          nfill = k;
          break;
        end
      end
      do_push = (q.size() < 8) && ($urandom_range(0, 2) != 0);
      do_resp = (nfill >= 0) && ($urandom_range(0, 1) == 1);
      rdy     = ($urandom_range(0, 3) != 0);
      rd      = $urandom;
      m.is_load  = 1'($urandom_range(0, 3) != 0);
      m.lsu_idx  = 4'($urandom_range(0, 15));
      m.addr_lo  = 2'($urandom_range(0, 3));
      m.size     = 2'($urandom_range(0, 2));
      m.sign_ext = 1'($urandom_range(0, 1));
      if (do_push) begin
        req_push = 1'b1;
        req_meta = m;
      end
      if (do_resp) drive_resp(q[nfill].m.lsu_idx, rd);
      wb_ready = rdy;
      #1;
      exp_v = (q.size() > 0) && q[0].f;
      byp   = 1'b0;
`ifdef UC_RESP_BYPASS_EN
      if (!exp_v && do_resp && nfill == 0) begin
        exp_v = 1'b1;
        byp   = 1'b1;
      end
`endif
      chk("rand_credit", 32'(credit_ok), 32'(q.size() < 8));
      chk("rand_wb_valid", 32'(wb_valid), 32'(exp_v));
      if (exp_v) begin
        exp_d = byp ? ref_align(q[0].m, rd) : ref_align(q[0].m, q[0].d);
        chk("rand_wb_idx", 32'(wb_lsu_idx), 32'(q[0].m.lsu_idx));
        chk("rand_wb_is_load", 32'(wb_is_load), 32'(q[0].m.is_load));
        chk("rand_wb_rddata", wb_rddata, exp_d);
      end
      if (do_resp) begin
        q[nfill].d = rd;
        q[nfill].f = 1'b1;
      end
      if (exp_v && rdy) void'(q.pop_front());
      if (do_push) q.push_back('{m, 32'h0, 1'b0});
      cyc();
    end
    chk("rand_err_order", 32'(err_order), 32'h0);
    chk("rand_err_ovf", 32'(err_ovf), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
